// File: rtl/alu_pkg.sv
// Shared ALU control codes and MULTU/DIVU sequencer definitions.
// Imported by the multiply/divide sequencer and by the top-level datapath.
package alu_pkg;

  localparam logic MD_MULTU = 1'b0;
  localparam logic MD_DIVU  = 1'b1;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the shared external ALU.
// Optional macro MULDIV_DIVZERO_FAST_EN: divide by zero completes in one cycle.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_y
);

  md_state_t        state;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] rem_shift;
  logic             rem_msb;
  logic             mul_carry;
  logic             div_take;
  logic             fast_dz;

  // The ALU only sees a 32-bit add, so the multiply carry is recovered locally.
  assign rem_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign rem_msb   = hi[WIDTH-1];
  assign mul_carry = (alu_y < hi);
  assign div_take  = rem_msb | (rem_shift >= b_reg);

`ifdef MULDIV_DIVZERO_FAST_EN
  assign fast_dz = (op == MD_DIVU) && (srcb == '0);
`else
  assign fast_dz = 1'b0;
`endif

  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      MUL: begin
        alu_a = hi;
        alu_b = b_reg;
      end
      DIV: begin
        alu_ctrl = ALU_SUB;
        alu_a    = rem_shift;
        alu_b    = b_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      b_reg <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            b_reg <= srcb;
            count <= CNT_W'(WIDTH - 1);
            if (fast_dz) begin
              state <= DONE;
              done  <= 1'b1;
              hi    <= srca;
              lo    <= '1;
            end else begin
              state <= (op == MD_DIVU) ? DIV : MUL;
              busy  <= 1'b1;
              hi    <= '0;
              lo    <= srca;
            end
          end
        end
        MUL: begin
          if (lo[0])
            {hi, lo} <= {mul_carry, alu_y, lo[WIDTH-1:1]};
          else
            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
          count <= count - 1'b1;
          if (count == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DIV: begin
          // Restoring step: keep the difference only when the divisor fits.
          if (div_take) begin
            hi <= alu_y;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= rem_shift;
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
